// File: rtl/ro_seven_seg_display_pkg.sv
// Shared types and helpers for the Ro seven-segment display slice.
// Holds the converter state encoding, the blank segment pattern and the
// BCD-digit to segment decoder (common anode, active-low, {g,f,e,d,c,b,a}).
package k2_display_pkg;

  typedef enum logic {IDLE, CONV} conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ro_seven_seg_display_if.sv
// Bundle between the processor-side Ro value and the display outputs.
// master drives Ro and watches the display; slave is the display block.
interface ro_seven_seg_display_if #(
  parameter int bits   = 8,
  parameter int DIGITS = 3
);
  logic [bits-1:0]     Ro;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic [4*DIGITS-1:0] bcd;
  logic                busy;

  modport master (output Ro, input seg, an, bcd, busy);
  modport slave  (input Ro, output seg, an, bcd, busy);
endinterface

// File: rtl/ro_seven_seg_display_bin2bcd_seq.sv
// Sequential double-dabble converter with change detection.
// IDLE watches Ro against the last converted value; CONV runs bits
// add-3/shift steps, then publishes the result one cycle later so that
// busy covers exactly the shifting cycles and bcd updates atomically.
import k2_display_pkg::*;

module bin2bcd_seq #(
  parameter int bits   = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [bits-1:0]     ro_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                busy_o
);

  localparam int CNTW = $clog2(bits + 1);
  localparam int BW   = 4 * DIGITS;

  conv_state_e     state_q, state_d;
  logic [bits-1:0] last_q, last_d;
  logic [bits-1:0] shift_q, shift_d;
  logic [BW-1:0]   scr_q, scr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            busy_q, busy_d;
  logic [BW-1:0]   adj;

  // Add-3 correction on every scratch nibble that is 5 or more.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state: change detection in IDLE, shift steps then publish in CONV.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (ro_i != last_q) begin
          last_d  = ro_i;
          shift_d = ro_i;
          scr_d   = '0;
          cnt_d   = CNTW'(bits);
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (cnt_q != '0) begin
          {scr_d, shift_d} = {adj[BW-2:0], shift_q, 1'b0};
          cnt_d = cnt_q - CNTW'(1);
          // busy drops together with the last shift
          if (cnt_q == CNTW'(1)) busy_d = 1'b0;
        end else begin
          bcd_d   = scr_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset aborts any conversion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= '0;
      shift_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/ro_seven_seg_display.sv
// Ro to multiplexed common-anode 7-segment display.
// Converts each new Ro to BCD and scans the digits, REFRESH_DIV clocks each.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero digit (digit 0 is always shown).
import k2_display_pkg::*;

module ro_seven_seg_display #(
  parameter int bits        = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ro_seven_seg_display_if.slave  dio
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] bcd_w;
  logic                busy_w;
  logic [CW-1:0]       refr_q, refr_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          digit;

  bin2bcd_seq #(.bits(bits), .DIGITS(DIGITS)) u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .ro_i   (dio.Ro),
    .bcd_o  (bcd_w),
    .busy_o (busy_w)
  );

  // Refresh divider and digit index; index steps when the divider wraps.
  always_comb begin
    refr_d = refr_q + CW'(1);
    idx_d  = idx_q;
    if (refr_q == CW'(REFRESH_DIV - 1)) begin
      refr_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  assign digit = bcd_w[4*int'(idx_q) +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;

  // Anode pattern and segments for the current digit, blanking leading zeros.
  always_comb begin
    msd = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd_w[4*i +: 4] != 4'd0) msd = IW'(i);
    end
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = (idx_q > msd) ? SEG_BLANK : seg_decode(digit);
  end
`else
  // Anode pattern and segments for the current digit, all digits shown.
  always_comb begin
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = seg_decode(digit);
  end
`endif

  // Scan registers; outputs are registered so the pins never glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refr_q <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
    end else begin
      refr_q <= refr_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign dio.an   = an_q;
  assign dio.seg  = seg_q;
  assign dio.bcd  = bcd_w;
  assign dio.busy = busy_w;

endmodule

// File: tb/tb_ro_seven_seg_display.sv
// Directed bench for ro_seven_seg_display (bits=8, DIGITS=3, REFRESH_DIV=4).
// Inputs change 1ns after a rising edge; outputs are sampled at that point.
module tb_ro_seven_seg_display;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  ro_seven_seg_display_if #(.bits(8), .DIGITS(3)) dio ();

  ro_seven_seg_display #(.bits(8), .DIGITS(3), .REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dio   (dio)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample the scan for 12 cycles and check segments against each anode.
  task automatic scan_check(input string tag, input logic [6:0] e0,
                            input logic [6:0] e1, input logic [6:0] e2);
    for (int i = 0; i < 12; i++) begin
      tick();
      case (dio.an)
        3'b110:  chk({tag, "_d0"}, {25'd0, dio.seg}, {25'd0, e0});
        3'b101:  chk({tag, "_d1"}, {25'd0, dio.seg}, {25'd0, e1});
        3'b011:  chk({tag, "_d2"}, {25'd0, dio.seg}, {25'd0, e2});
        default: chk({tag, "_an"}, {29'd0, dio.an}, 32'h6);
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_an [4];
    logic       synced;
    logic [2:0] prev;
    int         held;

    exp_an[0] = 3'b110; exp_an[1] = 3'b101; exp_an[2] = 3'b011; exp_an[3] = 3'b110;
    dio.Ro = 8'd0;

    // 1: reset state and first scan cycle
    repeat (3) tick();
    chk("rst_an", dio.an, 3'b111);
    chk("rst_seg", dio.seg, 7'h7F);
    chk("rst_bcd", dio.bcd, 12'h000);
    chk("rst_busy", dio.busy, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("first_an", dio.an, 3'b110);
    chk("first_seg", dio.seg, 7'h40);
    chk("idle_busy", dio.busy, 1'b0);

    // 2: 137, busy for 8 cycles, bcd 9 cycles after sampling
    dio.Ro = 8'd137;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("b137_busy", dio.busy, 1'b1);
    end
    tick();
    chk("b137_busy_end", dio.busy, 1'b0);
    chk("b137_bcd_early", dio.bcd, 12'h000);
    tick();
    chk("b137_bcd", dio.bcd, 12'h137);
    tick();
    scan_check("s137", 7'h78, 7'h30, 7'h79);

    // 3: 255, then the same value again causes no conversion
    dio.Ro = 8'd255;
    tick();
    chk("b255_busy", dio.busy, 1'b1);
    repeat (9) tick();
    chk("b255_bcd", dio.bcd, 12'h255);
    dio.Ro = 8'd255;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b255_rewrite_busy", dio.busy, 1'b0);
    end

    // 4: 5 then 13 during conversion; stale 005 then 013
    dio.Ro = 8'd5;
    repeat (3) tick();
    dio.Ro = 8'd13;
    repeat (7) tick();
    chk("b5_bcd", dio.bcd, 12'h005);
    chk("b5_busy", dio.busy, 1'b0);
    tick();
    chk("b13_start", dio.busy, 1'b1);
    repeat (8) tick();
    chk("b13_bcd_early", dio.bcd, 12'h005);
    tick();
    chk("b13_bcd", dio.bcd, 12'h013);

    // 5: anode sequence and hold length across the index wrap
    synced = 1'b0;
    for (int i = 0; i < 16 && !synced; i++) begin
      prev = dio.an;
      tick();
      if (dio.an == 3'b110 && prev != 3'b110) synced = 1'b1;
    end
    chk("scan_sync", {31'd0, synced}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("scan_seq", dio.an, exp_an[k]);
      prev = dio.an;
      held = 0;
      while (dio.an == prev && held < 10) begin
        tick();
        held++;
      end
      chk("scan_hold", held, 4);
    end

    // 6: reset during conversion of 200, then reconvert after release
    dio.Ro = 8'd200;
    tick();
    chk("b200_busy", dio.busy, 1'b1);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_an", dio.an, 3'b111);
    chk("mid_rst_seg", dio.seg, 7'h7F);
    chk("mid_rst_bcd", dio.bcd, 12'h000);
    chk("mid_rst_busy", dio.busy, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("b200_rebusy", dio.busy, 1'b1);
    repeat (9) tick();
    chk("b200_bcd", dio.bcd, 12'h200);

    dio.Ro = 8'd7;
    repeat (10) tick();
    chk("b7_bcd", dio.bcd, 12'h007);
    tick();
`ifdef LEADING_ZERO_BLANK_EN
    scan_check("s7", 7'h78, 7'h7F, 7'h7F);
`else
    scan_check("s7", 7'h78, 7'h40, 7'h40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
